// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding,
// default bit period and frame-width constants, plus the parity helper.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit per frame).
package uart_pkg;

  // 40 MHz clock / 9600 baud
  localparam int CLK_DIV_DEFAULT = 4166;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
`ifdef UART_RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + STOP_BITS;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4,
    ST_PARITY  = 3'd5
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RECOVER = 3'd4
  } rx_state_e;
`endif

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Single-clock byte FIFO for received characters. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_rx_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign rd_ok_s = pop && !empty;
  assign wr_ok_s = push && (!full || rd_ok_s);
  assign data    = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer advance on accepted push/pop; wrap is natural modulo 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) with a small receive FIFO, sticky error
// flags and a registered interrupt. Define UART_RX_PARITY_EN to add an even
// parity bit after the data bits and the parity_err output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  input  logic       err_clr,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       irq
);

  localparam logic [15:0] HALF_CNT = 16'(CLK_DIV / 2);
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  logic       sync1_r;
  logic       sync2_r;
  logic       rx_prev_r;
  logic       rx_s;

  rx_state_e  state_r;
  rx_state_e  state_nx_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nx_s;
  logic [2:0] bit_cnt_r;
  logic [2:0] bit_cnt_nx_s;
  logic [7:0] shift_r;
  logic [7:0] shift_nx_s;

  logic       push_s;
  logic       pop_s;
  logic       frame_set_s;
  logic       overrun_set_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
`ifdef UART_RX_PARITY_EN
  logic       par_set_s;
`endif

  assign rx_s = sync2_r;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      sync1_r   <= ser_rx;
      sync2_r   <= sync1_r;
      rx_prev_r <= sync2_r;
    end
  end

  // Receiver state, bit-period counter, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      bit_cnt_r <= bit_cnt_nx_s;
      shift_r   <= shift_nx_s;
    end
  end

  // Next-state logic: start-bit midpoint, then one sample per bit period.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r + 16'd1;
    bit_cnt_nx_s = bit_cnt_r;
    shift_nx_s   = shift_r;
    push_s       = 1'b0;
    frame_set_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set_s    = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        cnt_nx_s     = 16'd0;
        bit_cnt_nx_s = 3'd0;
        if (rx_prev_r && !rx_s) begin
          state_nx_s = ST_START;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == HALF_CNT) begin
          cnt_nx_s = 16'd0;
          if (!rx_s) begin
            state_nx_s = ST_DATA;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_r == DIV_LAST) begin
          cnt_nx_s     = 16'd0;
          shift_nx_s   = {rx_s, shift_r[7:1]};
          bit_cnt_nx_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nx_s = ST_PARITY;
`else
            state_nx_s = ST_STOP;
`endif
          end else begin
            state_nx_s = ST_DATA;
          end
        end else begin
          state_nx_s = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_r == DIV_LAST) begin
          cnt_nx_s = 16'd0;
          if (rx_s != even_parity(shift_r)) begin
            par_set_s  = 1'b1;
            state_nx_s = ST_RECOVER;
          end else begin
            state_nx_s = ST_STOP;
          end
        end else begin
          state_nx_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_r == DIV_LAST) begin
          cnt_nx_s = 16'd0;
          if (rx_s) begin
            push_s     = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            frame_set_s = 1'b1;
            state_nx_s  = ST_RECOVER;
          end
        end else begin
          state_nx_s = ST_STOP;
        end
      end
      ST_RECOVER: begin
        cnt_nx_s = 16'd0;
        if (rx_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RECOVER;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = 16'd0;
      end
    endcase
  end

  assign pop_s         = rd_en && !fifo_empty_s;
  assign overrun_set_s = push_s && fifo_full_s && !pop_s;
  assign rx_valid      = !fifo_empty_s;

  uart_rx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (shift_r),
    .pop       (pop_s),
    .data      (rd_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Sticky error flags: a set event in the same cycle wins over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set_s) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
      if (overrun_set_s) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Sticky parity error flag, same set-over-clear priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (par_set_s) begin
      parity_err <= 1'b1;
    end else if (err_clr) begin
      parity_err <= 1'b0;
    end
  end
`endif

  // Interrupt is a registered OR of the current status terms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
`ifdef UART_RX_PARITY_EN
      irq <= !fifo_empty_s || frame_err || overrun || parity_err;
`else
      irq <= !fifo_empty_s || frame_err || overrun;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a short bit period.
module tb_uart_rx_fifo;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       ser_rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic       err_clr;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif
  logic       irq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  uart_rx_fifo #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ser_rx     (ser_rx),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rx_valid   (rx_valid),
    .err_clr    (err_clr),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_bit();
    repeat (DIV) @(negedge clk);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_p(input logic [7:0] b, input logic par, input logic stop_lvl);
    ser_rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      wait_bit();
    end
    ser_rx = par;
    wait_bit();
    ser_rx = stop_lvl;
    wait_bit();
    ser_rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    send_frame_p(b, ^b, stop_lvl);
  endtask
`else
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    ser_rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      wait_bit();
    end
    ser_rx = stop_lvl;
    wait_bit();
    ser_rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask
`endif

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h expected 00", rd_data);
    else pass_cnt++;
    total_cnt++;
    if ({frame_err, overrun} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {frame_err, overrun});
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
    else pass_cnt++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL idle_rx_valid: got %b expected 0", rx_valid);
    else pass_cnt++;
  endtask

  task automatic test_single_byte();
    send_frame(8'hA5, 1'b1);
    total_cnt++;
    if (rx_valid !== 1'b1) $display("FAIL a5_rx_valid: got %b expected 1", rx_valid);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== 8'hA5) $display("FAIL a5_rd_data: got %h expected a5", rd_data);
    else pass_cnt++;
    total_cnt++;
    if (frame_err !== 1'b0) $display("FAIL a5_frame_err: got %b expected 0", frame_err);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL a5_irq: got %b expected 1", irq);
    else pass_cnt++;
    pop_one();
    total_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL a5_pop_empty: got %b expected 0", rx_valid);
    else pass_cnt++;
  endtask

  task automatic test_empty_read();
    rd_en = 1'b1;
    repeat (2) @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL empty_read_valid: got %b expected 0", rx_valid);
    else pass_cnt++;
    send_frame(8'h5A, 1'b1);
    total_cnt++;
    if (rd_data !== 8'h5A || rx_valid !== 1'b1) $display("FAIL empty_read_next: got %h/%b expected 5a/1", rd_data, rx_valid);
    else pass_cnt++;
    pop_one();
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
    end
    total_cnt++;
    if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", overrun);
    else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i);
      total_cnt++;
      if (rx_valid !== 1'b1 || rd_data !== exp) $display("FAIL ovr_data%0d: got %h/%b expected %h/1", i, rd_data, rx_valid, exp);
      else pass_cnt++;
      pop_one();
    end
    total_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL ovr_drained: got %b expected 0", rx_valid);
    else pass_cnt++;
    pulse_err_clr();
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", overrun);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL ovr_irq_clear: got %b expected 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0);
    total_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL ferr_no_push: got %b expected 0", rx_valid);
    else pass_cnt++;
    total_cnt++;
    if (frame_err !== 1'b1) $display("FAIL ferr_flag: got %b expected 1", frame_err);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL ferr_irq: got %b expected 1", irq);
    else pass_cnt++;
    pulse_err_clr();
    total_cnt++;
    if (frame_err !== 1'b0) $display("FAIL ferr_clear: got %b expected 0", frame_err);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL ferr_irq_clear: got %b expected 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    ser_rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    ser_rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    total_cnt++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0) $display("FAIL glitch: got %b/%b expected 0/0", rx_valid, frame_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    ser_rx = 1'b0;
    wait_bit();
    ser_rx = 1'b1;
    repeat (4) wait_bit();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6 * DIV) @(negedge clk);
    total_cnt++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0) $display("FAIL rst_abort: got %b/%b expected 0/0", rx_valid, frame_err);
    else pass_cnt++;
    send_frame(8'h55, 1'b1);
    total_cnt++;
    if (rx_valid !== 1'b1 || rd_data !== 8'h55) $display("FAIL rst_next_byte: got %h/%b expected 55/1", rd_data, rx_valid);
    else pass_cnt++;
    pop_one();
    total_cnt++;
    if (rx_valid !== 1'b0) $display("FAIL rst_only_one: got %b expected 0", rx_valid);
    else pass_cnt++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame_p(8'h07, 1'b0, 1'b1);
    total_cnt++;
    if (parity_err !== 1'b1 || rx_valid !== 1'b0) $display("FAIL par_bad: got %b/%b expected 1/0", parity_err, rx_valid);
    else pass_cnt++;
    pulse_err_clr();
    send_frame_p(8'h07, 1'b1, 1'b1);
    total_cnt++;
    if (parity_err !== 1'b0 || rx_valid !== 1'b1 || rd_data !== 8'h07) $display("FAIL par_good: got %b/%b/%h expected 0/1/07", parity_err, rx_valid, rd_data);
    else pass_cnt++;
    pop_one();
  endtask
`endif

  initial begin
    ser_rx  = 1'b1;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    rst     = 1'b1;
    test_reset();
    test_single_byte();
    test_empty_read();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4166, meaning clk cycles per serial bit (40 MHz / 9600 baud); legal range 8..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning received-byte buffer entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ser_rx  input  1  serial line from tbuart TX: idle high, 8N1, LSB first.
REQ-006 SHALL have port rd_en  input  1  pop request for FIFO head byte.
REQ-007 SHALL have port rd_data  output  8  FIFO head byte, valid while rx_valid=1.
REQ-008 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-010 SHALL have port frame_err  output  1  sticky flag: stop bit sampled low.
REQ-011 SHALL have port overrun  output  1  sticky flag: byte dropped on full FIFO.
REQ-012 SHALL have port irq  output  1  registered interrupt: rx_valid | frame_err | overrun (| parity_err).

Function
REQ-013 SHALL pass ser_rx through a 2-flop synchronizer; all sampling uses the synchronized value (2-cycle input latency).
REQ-014 SHALL implement states IDLE, START, DATA, STOP, RECOVER (PARITY when REQ-030 applies).
REQ-015 IDLE->START on synchronized high-to-low edge; bit counter reset to 0.
REQ-016 START: at count CLK_DIV/2 sample line; low -> DATA, high -> IDLE (glitch rejected, nothing pushed).
REQ-017 DATA: sample every CLK_DIV cycles from the start-bit midpoint; shift LSB first; after 8th bit -> STOP.
REQ-018 STOP: sample at mid-bit; high -> push byte, IDLE; low -> set frame_err, discard byte, RECOVER.
REQ-019 RECOVER: stay until synchronized line high, then IDLE.
REQ-020 Push SHALL occur on the stop-bit sample cycle; rx_valid rises the following cycle.
REQ-021 rd_data SHALL be driven from FIFO head storage combinationally; rd_en with rx_valid=1 pops on the next clk edge; rd_en while empty SHALL be ignored.
REQ-022 Push while full and no pop: byte dropped, overrun set, FIFO contents unchanged.
REQ-023 Push and pop in the same cycle while full: both take effect, no overrun.
REQ-024 Pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH; full = MSBs differ, rest equal.
REQ-025 err_clr SHALL clear frame_err/overrun next cycle; a same-cycle set event takes priority over clear.
REQ-026 irq SHALL be one cycle behind its source terms.

Reset
REQ-027 On rst: state IDLE, counters 0, FIFO empty, rx_valid=0, rd_data=0, frame_err=0, overrun=0, irq=0, synchronizer flops=1.
REQ-028 rst asserted mid-frame SHALL abort the frame with no push; after release the receiver waits for a fresh falling edge.

Configuration
REQ-029 Macro UART_RX_PARITY_EN SHALL select parity support.
REQ-030 Defined: 9th bit after data = even parity, state PARITY between DATA and STOP; mismatch sets sticky output parity_err (cleared by err_clr) and discards the byte; parity_err included in irq.
REQ-031 Undefined: no PARITY state, no parity_err port, 8N1 only.

Structure
REQ-032 Shared package uart_pkg SHALL hold the state enumeration, default CLK_DIV, and frame-width constants.
REQ-033 FIFO SHALL be sub-module uart_rx_sync_fifo (push, pop, data, full, empty); FSM and flags stay in the top.

Verification
REQ-034 tbuart sends 0xA5, 8N1 at CLK_DIV -> rx_valid=1, rd_data=0xA5, frame_err=0, irq=1.
REQ-035 Send 0x01,0x02,0x03,0x04,0x05 with no reads, depth 4 -> FIFO holds 01..04, overrun=1; 4 pops return 01..04.
REQ-036 Drive 0x3C with stop bit forced low -> no push, frame_err=1; err_clr pulse -> frame_err=0, irq=0.
REQ-037 ser_rx low pulse of CLK_DIV/4 cycles -> returns to IDLE, rx_valid stays 0.
REQ-038 Assert rst after 4 data bits of 0xFF, release, send 0x55 -> only 0x55 received.
REQ-039 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err=1, no push; with parity 1 -> 0x07 pushed.
